// File: rtl/sp_rfifo_arbiter.sv
// rtl/sp_rfifo_arbiter.sv - four-way round-robin read-FIFO arbiter with a single outstanding memory read (optional watchdog: SP_ARB_TIMEOUT_EN)
module sp_rfifo_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [3:0]                    rFIFO_empty,
    input  logic [4*(TAG_W+ADDR_W)-1:0]   rFIFO_rdata,
    output logic [3:0]                    rFIFO_REN,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          respFIFO_full,
    output logic                          respFIFO_WEN,
    output logic [2+TAG_W+DATA_W-1:0]     respFIFO_wdata,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int ENT_W = TAG_W + ADDR_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [1:0]          src_q, src_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [DATA_W-1:0]   data_q, data_d;

`ifdef SP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    logic [ENT_W-1:0]    entry [4];
    logic                grant_found;
    logic [1:0]          grant_idx;
    logic [1:0]          cand;
    logic [3:0]          ren;

    // Split the packed show-ahead heads and search round-robin from rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        cand        = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            entry[i] = rFIFO_rdata[i*ENT_W +: ENT_W];
        end
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!grant_found && !rFIFO_empty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state and output decode; everything defaults to idle values
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        src_d          = src_q;
        addr_d         = addr_q;
        tag_d          = tag_q;
        data_d         = data_q;
        ren            = 4'b0000;
        mem_req        = 1'b0;
        mem_addr       = '0;
        respFIFO_WEN   = 1'b0;
        respFIFO_wdata = '0;
        timeout_err    = 1'b0;
`ifdef SP_ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    ren[grant_idx] = 1'b1;
                    src_d          = grant_idx;
                    addr_d         = entry[grant_idx][ADDR_W-1:0];
                    tag_d          = entry[grant_idx][ENT_W-1:ADDR_W];
                    rr_ptr_d       = grant_idx + 2'd1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ready) begin
                    state_d = WAIT;
`ifdef SP_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                // Read data on the limit cycle still takes the normal path
                if (mem_rvalid) begin
                    data_d  = mem_rdata;
                    state_d = RESP;
                end
`ifdef SP_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (!respFIFO_full) begin
                    respFIFO_WEN   = 1'b1;
                    respFIFO_wdata = {src_q, tag_q, data_q};
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop strobe is gated by reset so a non-empty FIFO cannot be popped while held in reset
    assign rFIFO_REN = ren & {4{nRST}};
    assign busy      = (state_q != IDLE);

    // State and latch registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd0;
            src_q    <= 2'd0;
            addr_q   <= '0;
            tag_q    <= '0;
            data_q   <= '0;
`ifdef SP_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
`ifdef SP_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: doc/sp_rfifo_arbiter.md
SP_RFIFO_ARBITER -- requirements
Module: sp_rfifo_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  32  load address width
  TAG_W   8   request tag width: type, matrix id and row id
  DATA_W  64  row data width
  TIMEOUT 255 WAIT watchdog limit, in cycles (used only with SP_ARB_TIMEOUT_EN)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  CLK  in  1  single clock; all state on rising edge
  nRST  in  1  asynchronous, active-low reset
  rFIFO_empty  in  4  per-requester empty flag; bit i is rFIFO i
  rFIFO_rdata  in  4*(TAG_W+ADDR_W)  show-ahead heads; entry i at [i*(TAG_W+ADDR_W) +: TAG_W+ADDR_W]; addr in low ADDR_W bits, tag above
  rFIFO_REN  out  4  one-hot pop strobe
  mem_req  out  1  memory read request valid
  mem_addr  out  ADDR_W  request address
  mem_ready  in  1  memory accepts request
  mem_rvalid  in  1  read data valid
  mem_rdata  in  DATA_W  read data
  respFIFO_full  in  1  response FIFO full
  respFIFO_WEN  out  1  response write strobe
  respFIFO_wdata  out  2+TAG_W+DATA_W  {src[1:0], tag, data}
  busy  out  1  high in any state other than IDLE
  timeout_err  out  1  one-cycle watchdog pulse

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP; only one request SHALL be outstanding at a time.
REQ-004 In IDLE, with any rFIFO_empty bit low, the block SHALL grant round-robin: search starts at rr_ptr, ascending modulo 4.
REQ-005 The grant cycle SHALL assert rFIFO_REN[g] for exactly one cycle, latch rdata entry g and g, set rr_ptr=(g+1) mod 4, and go to ISSUE.
REQ-006 In IDLE, with all rFIFO_empty bits high, the block SHALL stay in IDLE with rFIFO_REN=0.
REQ-007 In ISSUE, mem_req SHALL be 1 and mem_addr SHALL equal the latched address, held stable until the mem_ready cycle; then the FSM SHALL go to WAIT.
REQ-008 mem_req SHALL be 0 and mem_addr SHALL be 0 outside ISSUE.
REQ-009 In WAIT, mem_rvalid SHALL latch mem_rdata and move to RESP; mem_rvalid in any other state SHALL be ignored.
REQ-010 In RESP, respFIFO_WEN SHALL be asserted only when respFIFO_full=0, with wdata={g, latched tag, latched data}.
REQ-011 In RESP, the FSM SHALL return to IDLE on the cycle WEN is asserted, and hold in RESP while full.
REQ-012 A new grant SHALL NOT occur in the same cycle as respFIFO_WEN.
REQ-013 Minimum REN-to-WEN latency, with mem_ready=1 in ISSUE, mem_rvalid=1 on the first WAIT cycle and no full, SHALL be 3 cycles.
REQ-014 rr_ptr SHALL wrap 3->0; a requester that stays non-empty SHALL be granted at least once every 4 grants.

Reset
REQ-015 nRST low SHALL immediately force state=IDLE, rr_ptr=0, all latches to 0, and all outputs to 0, independent of CLK.
REQ-016 A request in flight at reset SHALL be dropped; late mem_rvalid after reset release SHALL be ignored per REQ-009.

Configuration
REQ-017 Macro SP_ARB_TIMEOUT_EN, when defined, SHALL add a watchdog: a counter cleared on WAIT entry, incremented each WAIT cycle without mem_rvalid.
REQ-018 With SP_ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT the block SHALL pulse timeout_err for 1 cycle, drop the request without respFIFO_WEN, and go to IDLE.
REQ-019 With SP_ARB_TIMEOUT_EN defined, mem_rvalid on the same cycle the count reaches TIMEOUT SHALL win, giving the normal RESP path.
REQ-020 Without SP_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and WAIT SHALL persist indefinitely.

Verification
REQ-021 Single request: rFIFO1 head addr=0x100, tag=0x2A, mem_ready=1, rvalid 1 cycle after issue with data=0xDEAD -> REN=0010 at t0, mem_req with addr=0x100 at t1, WEN at t3 with wdata={1,0x2A,0xDEAD}.
REQ-022 Fairness: all four rFIFOs non-empty, zero-wait memory -> grant order 0,1,2,3,0 with rr_ptr wrapping.
REQ-023 Backpressure: mem_ready low 5 cycles, then respFIFO_full high 4 cycles in RESP -> mem_addr stable for all 5 cycles, WEN only on the first not-full cycle, no extra REN.
REQ-024 Reset mid-WAIT: nRST low while in WAIT, then rvalid after release -> all outputs 0 immediately, no WEN, next grant starts at requester 0.
REQ-025 Timeout (macro on, TIMEOUT=4): no rvalid -> timeout_err pulses on the 4th WAIT cycle, no WEN, return to IDLE; macro off -> busy stays high, timeout_err=0.
